// File: rtl/power_fsm_pkg.sv
// Shared encodings and helpers for the BLE power-mode controller.
// Optional auto-expiry of SLEEP is enabled with AUTO_DEEPSLEEP_EN.
package power_fsm_pkg;

  localparam logic [1:0] ST_SHUTDOWN  = 2'b00;
  localparam logic [1:0] ST_DEEPSLEEP = 2'b01;
  localparam logic [1:0] ST_SLEEP     = 2'b10;
  localparam logic [1:0] ST_ACTIVE    = 2'b11;

  typedef enum logic [1:0] {
    PS_SHUTDOWN  = ST_SHUTDOWN,
    PS_DEEPSLEEP = ST_DEEPSLEEP,
    PS_SLEEP     = ST_SLEEP,
    PS_ACTIVE    = ST_ACTIVE
  } power_state_e;

  // Bits needed to hold 0..lim-1, never less than one.
  function automatic int cnt_w(input int lim);
    return (lim < 2) ? 1 : $clog2(lim);
  endfunction

endpackage

// File: rtl/power_idle_timer.sv
// Saturating cycle counter; done flags the last count before LIMIT.
// Used for both the ACTIVE idle count and the SLEEP dwell count.
module power_idle_timer
  import power_fsm_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int WIDTH = cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_cnt == LAST);
  assign o_done = w_done;

  // Count up while enabled, hold at LAST, clear on request.
  always_ff @(posedge clk) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (i_inc && !w_done)
      r_cnt <= r_cnt + ONE;
  end

endmodule

// File: rtl/power_fsm.sv
// Always-on power-mode FSM: SHUTDOWN/DEEPSLEEP/SLEEP/ACTIVE.
// Define AUTO_DEEPSLEEP_EN to let SLEEP expire on its own.
module power_fsm
  import power_fsm_pkg::*;
#(
  parameter int IDLE_CYCLES   = 4,
  parameter int SLEEP_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wakeup_event,
  input  logic       radio_request,
  input  logic       radio_idle,
  input  logic       cpu_idle,
  input  logic       timer_expired,
  input  logic       shutdown_cmd,
  output logic [1:0] power_state
);

  power_state_e r_state;
  logic         r_radio_busy;
  logic         w_idle;
  logic         w_idle_done;
  logic         w_idle_clr;
  logic         w_wake;
  logic         w_expiry;

  assign w_idle = cpu_idle & ~r_radio_busy & ~radio_request;
  assign w_wake = wakeup_event | radio_request;

  // Idle count restarts on any break in idleness or on leaving ACTIVE.
  assign w_idle_clr = (r_state != PS_ACTIVE) | ~w_idle
                    | shutdown_cmd | w_idle_done;

  power_idle_timer #(
    .LIMIT (IDLE_CYCLES)
  ) u_idle_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (1'b1),
    .i_clr  (w_idle_clr),
    .o_done (w_idle_done)
  );

`ifdef AUTO_DEEPSLEEP_EN
  logic w_sleep_done;
  logic w_sleep_clr;

  // Dwell count restarts whenever SLEEP is left for any reason.
  assign w_sleep_clr = (r_state != PS_SLEEP) | shutdown_cmd
                     | w_wake | timer_expired | w_sleep_done;

  power_idle_timer #(
    .LIMIT (SLEEP_TIMEOUT)
  ) u_sleep_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (1'b1),
    .i_clr  (w_sleep_clr),
    .o_done (w_sleep_done)
  );

  assign w_expiry = timer_expired | w_sleep_done;
`else
  assign w_expiry = timer_expired;
`endif

  // State register; shutdown overrides all wake sources.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PS_DEEPSLEEP;
    end else if (shutdown_cmd) begin
      r_state <= PS_SHUTDOWN;
    end else begin
      case (r_state)
        PS_SHUTDOWN:
          if (wakeup_event) r_state <= PS_ACTIVE;
        PS_DEEPSLEEP:
          if (w_wake) r_state <= PS_ACTIVE;
        PS_SLEEP:
          if (w_wake)        r_state <= PS_ACTIVE;
          else if (w_expiry) r_state <= PS_DEEPSLEEP;
        PS_ACTIVE:
          if (w_idle && w_idle_done) r_state <= PS_SLEEP;
        default:
          r_state <= PS_DEEPSLEEP;
      endcase
    end
  end

  // Radio busy: request sets (wins over idle), shutdown clears.
  always_ff @(posedge clk) begin
    if (reset || shutdown_cmd)
      r_radio_busy <= 1'b0;
    else if (radio_request)
      r_radio_busy <= 1'b1;
    else if (radio_idle)
      r_radio_busy <= 1'b0;
  end

  assign power_state = r_state;

endmodule

// File: tb/tb_power_fsm.sv
// Scoreboard bench for power_fsm: stimulus queues expected states,
// a monitor pops and compares one entry after every rising edge.
module tb_power_fsm;

  localparam logic [6:0] R  = 7'd64;
  localparam logic [6:0] W  = 7'd32;
  localparam logic [6:0] RQ = 7'd16;
  localparam logic [6:0] RI = 7'd8;
  localparam logic [6:0] CI = 7'd4;
  localparam logic [6:0] T  = 7'd2;
  localparam logic [6:0] SD = 7'd1;
  localparam logic [6:0] NO = 7'd0;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  typedef struct {
    bit         chk;
    logic [1:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wakeup_event = 1'b0;
  logic       radio_request = 1'b0;
  logic       radio_idle = 1'b0;
  logic       cpu_idle = 1'b0;
  logic       timer_expired = 1'b0;
  logic       shutdown_cmd = 1'b0;
  logic [1:0] power_state;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  power_fsm #(
    .IDLE_CYCLES   (4),
    .SLEEP_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wakeup_event  (wakeup_event),
    .radio_request (radio_request),
    .radio_idle    (radio_idle),
    .cpu_idle      (cpu_idle),
    .timer_expired (timer_expired),
    .shutdown_cmd  (shutdown_cmd),
    .power_state   (power_state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [6:0] in, input logic [1:0] exp,
                     input bit chk, input string name);
    exp_t e;
    @(negedge clk);
    reset         = in[6];
    wakeup_event  = in[5];
    radio_request = in[4];
    radio_idle    = in[3];
    cpu_idle      = in[2];
    timer_expired = in[1];
    shutdown_cmd  = in[0];
    e.chk  = chk;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic rep(input int n, input logic [6:0] in,
                     input logic [1:0] exp, input string name);
    for (int i = 0; i < n; i++) cyc(in, exp, 1'b1, name);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          checks++;
          if (power_state !== e.exp) begin
            failures++;
            $display("FAIL %s: power_state=%b expected=%b at %0t",
                     e.name, power_state, e.exp, $time);
          end
        end
      end
    end
  end

  initial begin
    // 1: reset, release, wake from DEEPSLEEP
    rep(2, R, S01, "reset");
    cyc(NO, S01, 1'b1, "post_reset");
    cyc(T | CI, S01, 1'b1, "deep_hold");
    cyc(W, S11, 1'b1, "deep_wake");
    // 2: radio keeps ACTIVE despite idle CPU
    cyc(RQ, S11, 1'b1, "radio_req");
    rep(10, CI, S11, "radio_busy_hold");
    cyc(RI | CI, S11, 1'b1, "radio_idle");
    rep(3, CI, S11, "idle_count");
    cyc(CI, S10, 1'b1, "idle_to_sleep");
    // 3: timer expiry then radio wake
    cyc(T, S01, 1'b1, "sleep_timer");
    cyc(RQ, S11, 1'b1, "deep_radio_wake");
    // 4: shutdown beats wakeup; SHUTDOWN ignores radio
    cyc(SD | W, S00, 1'b1, "shutdown_prio");
    cyc(RQ, S00, 1'b1, "shut_radio_ign");
    cyc(T | CI, S00, 1'b1, "shut_other_ign");
    cyc(W, S11, 1'b1, "shut_wake");
    cyc(W | RI, S11, 1'b1, "active_wake_ign");
    // 5: broken idle run restarts the count
    rep(3, CI, S11, "idle_partial");
    cyc(NO, S11, 1'b1, "idle_break");
    rep(3, CI, S11, "idle_restart");
    cyc(CI, S10, 1'b1, "idle_sleep2");
    cyc(W | T, S11, 1'b1, "wake_beats_exp");
    rep(3, CI, S11, "idle_again");
    cyc(CI, S10, 1'b1, "idle_sleep3");
    cyc(SD | W, S00, 1'b1, "sleep_shutdown");
    cyc(W, S11, 1'b1, "shut_wake2");
    rep(3, CI, S11, "idle_again2");
    cyc(CI, S10, 1'b1, "idle_sleep4");
    // 6: SLEEP dwell with no inputs
`ifdef AUTO_DEEPSLEEP_EN
    rep(15, NO, S10, "sleep_dwell");
    cyc(NO, S01, 1'b1, "auto_deep");
    cyc(W, S11, 1'b1, "auto_wake");
    rep(3, CI, S11, "idle_again3");
    cyc(CI, S10, 1'b1, "idle_sleep5");
    rep(5, NO, S10, "sleep_dwell2");
`else
    rep(100, NO, S10, "sleep_hold");
`endif
    cyc(R | W, S01, 1'b1, "reset_mid_sleep");
    cyc(W | R, S01, 1'b1, "reset_beats_wake");
    cyc(RQ | SD, S00, 1'b1, "deep_shutdown");
    cyc(NO, S00, 1'b1, "shut_hold");
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
